imem_axi_rd_bridge: RTL

//  Responder for the 128-bit instruction-memory uni_if: the master end of iCache_wrapper's iMemIf_M.

---
 rtl/imem_axi_rd_bridge_pkg.sv | 18 +
 rtl/uni_if.sv | 17 +
 rtl/imem_axi_rd_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/imem_axi_rd_bridge_pkg.sv
// Shared types and AXI constants for the instruction-memory AXI read bridge.
package imem_axi_rd_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned LINE_BYTES     = 16;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/uni_if.sv
// Generic request/response memory interface between the iCache wrapper and its backing memory.
interface uni_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic              reqtyp;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic              cachable;
  logic [DATA_W-1:0] rdata;

  modport Master (output valid, reqtyp, addr, wdata, size, cachable, input ready, rdata);
  modport Slave  (input valid, reqtyp, addr, wdata, size, cachable, output ready, rdata);
endinterface

// File: rtl/imem_axi_rd_bridge.sv
// Turns each 128-bit instruction-memory read into one AXI4 read burst:
// a 2-beat line fill when cachable, a single sized beat otherwise.
module imem_axi_rd_bridge
  import imem_axi_rd_bridge_pkg::*;
#(
  parameter int AXI_ID = 0,
  parameter int ID_W   = 4,
  parameter int AXI_DW = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  uni_if.Slave              iMemIf_S,
  output logic              o_axi_arvalid,
  input  logic              i_axi_arready,
  output logic [31:0]       o_axi_araddr,
  output logic [ID_W-1:0]   o_axi_arid,
  output logic [7:0]        o_axi_arlen,
  output logic [2:0]        o_axi_arsize,
  output logic [1:0]        o_axi_arburst,
  input  logic              i_axi_rvalid,
  output logic              o_axi_rready,
  input  logic [AXI_DW-1:0] i_axi_rdata,
  input  logic [1:0]        i_axi_rresp,
  input  logic              i_axi_rlast,
  output logic              o_rd_err
);

  state_t              state;
  logic [31:0]         addr_q;
  logic [1:0]          size_q;
  logic                cach_q;
  logic [1:0]          beat_cnt;
  logic                err_q;
  logic [2*AXI_DW-1:0] line_buf;
  logic                unused_wdata;

  assign unused_wdata = ^iMemIf_S.wdata;

  function automatic logic [AXI_DW-1:0] align_beat(input logic [AXI_DW-1:0] d,
                                                   input logic [2:0]        off);
    return d >> {off, 3'b000};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      cach_q   <= 1'b0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iMemIf_S.valid) begin
            if (iMemIf_S.reqtyp == REQ_READ) begin
              addr_q   <= iMemIf_S.addr[31:0];
              size_q   <= iMemIf_S.size;
              cach_q   <= iMemIf_S.cachable;
              beat_cnt <= '0;
              err_q    <= 1'b0;
              line_buf <= '0;
              state    <= AR;
            end else begin
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        end
        AR: begin
          if (i_axi_arready) state <= R;
        end
        R: begin
          if (i_axi_rvalid) begin
            // beat_cnt stops at 2 so beats beyond the line are dropped
            if (beat_cnt == 2'd0)      line_buf[AXI_DW-1:0]        <= i_axi_rdata;
            else if (beat_cnt == 2'd1) line_buf[2*AXI_DW-1:AXI_DW] <= i_axi_rdata;
            if (beat_cnt != 2'd2) beat_cnt <= beat_cnt + 2'd1;
            err_q <= err_q | (i_axi_rresp != AXI_RESP_OKAY);
            if (i_axi_rlast) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_axi_arvalid = (state == AR);
  assign o_axi_rready  = (state == R);
  assign o_axi_araddr  = cach_q ? (addr_q & ~32'(LINE_BYTES - 1)) : addr_q;
  assign o_axi_arlen   = cach_q ? 8'd1 : 8'd0;
  assign o_axi_arsize  = cach_q ? 3'd3 : {1'b0, size_q};
  assign o_axi_arburst = AXI_BURST_INCR;
  assign o_axi_arid    = ID_W'(AXI_ID);

  assign iMemIf_S.ready = (state == RESP);
  assign iMemIf_S.rdata = cach_q ? line_buf
                                 : {{AXI_DW{1'b0}}, align_beat(line_buf[AXI_DW-1:0], addr_q[2:0])};
  assign o_rd_err       = (state == RESP) & err_q;

endmodule
